// File: rtl/s510_phase_ctrl.sv
// Traffic/phase controller: round-robin grant over NCH request channels with programmable
// GREEN/YELLOW/CLEAR/PED countdowns and a latched pedestrian override; all outputs registered.
module s510_phase_ctrl #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCH-1:0]   req,
  input  logic             john,
  input  logic [CNT_W-1:0] t_green,
  input  logic [CNT_W-1:0] t_yellow,
  input  logic [CNT_W-1:0] t_clear,
  input  logic [CNT_W-1:0] t_ped,
  output logic [NCH-1:0]   grant,
  output logic [2:0]       phase,
  output logic             ped_walk,
  output logic             john_pend,
  output logic             done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GREEN  = 3'd1;
  localparam logic [2:0] YELLOW = 3'd2;
  localparam logic [2:0] CLEAR  = 3'd3;
  localparam logic [2:0] PED    = 3'd4;
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]   grant_q, grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    idx_q, idx_d;
  logic             john_pend_q, john_pend_d;
  logic             ped_walk_q, ped_walk_d;
  logic             done_q, done_d;
  logic [PW-1:0]    arb_idx;
  logic             arb_found;
  logic             last;

  // First set request at or above ptr, wrapping to 0.
  always_comb begin
    int j;
    j         = 0;
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NCH) j = j - NCH;
      if (!arb_found && req[j]) begin
        arb_found = 1'b1;
        arb_idx   = PW'(j);
      end
    end
  end

  always_comb begin
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    john_pend_d = john_pend_q | john;
    last        = (cnt_q == '0);
    case (phase_q)
      IDLE: begin
        if (john_pend_q || john) begin
          phase_d = PED;
          cnt_d   = t_ped;
        end else if (arb_found) begin
          phase_d = GREEN;
          cnt_d   = t_green;
          grant_d = NCH'(1) << arb_idx;
          idx_d   = arb_idx;
        end
      end
      GREEN: begin
        if (last) begin
          phase_d = YELLOW;
          cnt_d   = t_yellow;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      YELLOW: begin
        if (last) begin
          phase_d = CLEAR;
          cnt_d   = t_clear;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CLEAR: begin
        if (last) begin
          ptr_d = (idx_q == PW'(NCH - 1)) ? '0 : idx_q + PW'(1);
          if (john_pend_q) begin
            phase_d = PED;
            cnt_d   = t_ped;
          end else begin
            phase_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PED: begin
        if (last) begin
          phase_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        phase_d = IDLE;
        cnt_d   = '0;
        grant_d = '0;
      end
    endcase
    // Entering PED serves the request, including a john pulse on that same edge.
    if (phase_d == PED && phase_q != PED) john_pend_d = 1'b0;
    done_d     = (phase_d == CLEAR) && (cnt_d == '0);
    ped_walk_d = (phase_d == PED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      john_pend_q <= 1'b0;
      ped_walk_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      john_pend_q <= john_pend_d;
      ped_walk_q  <= ped_walk_d;
      done_q      <= done_d;
    end
  end

  assign phase     = phase_q;
  assign grant     = grant_q;
  assign ped_walk  = ped_walk_q;
  assign john_pend = john_pend_q;
  assign done      = done_q;

endmodule

// File: tb/tb_s510_phase_ctrl.sv
// Directed bench for s510_phase_ctrl: stimulus queues the expected post-edge outputs,
// a monitor pops one entry per clock and compares.
module tb_s510_phase_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'h0;
  logic       john = 1'b0;
  logic [7:0] t_green = 8'd3;
  logic [7:0] t_yellow = 8'd1;
  logic [7:0] t_clear = 8'd0;
  logic [7:0] t_ped = 8'd2;
  logic [3:0] grant;
  logic [2:0] phase;
  logic       ped_walk;
  logic       john_pend;
  logic       done;

  typedef struct {
    logic [2:0] ph;
    logic [3:0] g;
    logic       walk;
    logic       pend;
    logic       dn;
    int         step;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   step = 0;

  s510_phase_ctrl #(.NCH(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .req(req), .john(john),
    .t_green(t_green), .t_yellow(t_yellow), .t_clear(t_clear), .t_ped(t_ped),
    .grant(grant), .phase(phase), .ped_walk(ped_walk), .john_pend(john_pend), .done(done)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs and record the outputs expected after the next rising edge.
  task automatic cyc(input logic rst, input logic [3:0] r, input logic j,
                     input logic [2:0] ph, input logic [3:0] g, input logic pend, input logic dn);
    exp_t e;
    @(negedge clock);
    reset = rst;
    req   = r;
    john  = j;
    e.ph   = ph;
    e.g    = g;
    e.walk = (ph == 3'd4);
    e.pend = pend;
    e.dn   = dn;
    e.step = step;
    exp_q.push_back(e);
    step++;
  endtask

  task automatic set_timers(input logic [7:0] g, input logic [7:0] y, input logic [7:0] c, input logic [7:0] p);
    t_green  = g;
    t_yellow = y;
    t_clear  = c;
    t_ped    = p;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (phase !== e.ph || grant !== e.g || ped_walk !== e.walk ||
            john_pend !== e.pend || done !== e.dn) begin
          fails++;
          $display("FAIL step %0d: got phase=%0d grant=%b walk=%b pend=%b done=%b, expected phase=%0d grant=%b walk=%b pend=%b done=%b",
                   e.step, phase, grant, ped_walk, john_pend, done, e.ph, e.g, e.walk, e.pend, e.dn);
        end
      end
    end
  end

  initial begin
    // Reset held with all requests and john asserted
    cyc(1, 4'hF, 1, 0, 4'b0000, 0, 0);
    cyc(1, 4'hF, 1, 0, 4'b0000, 0, 0);
    cyc(0, 4'h0, 0, 0, 4'b0000, 0, 0);

    // req=0101 from ptr=0: 4 GREEN, 2 YELLOW, 1 CLEAR, then channel 2
    cyc(0, 4'b0101, 0, 1, 4'b0001, 0, 0);
    repeat (3) cyc(0, 4'b0101, 0, 1, 4'b0001, 0, 0);
    repeat (2) cyc(0, 4'b0101, 0, 2, 4'b0001, 0, 0);
    cyc(0, 4'b0101, 0, 3, 4'b0000, 0, 1);
    cyc(0, 4'b0101, 0, 0, 4'b0000, 0, 0);
    cyc(0, 4'b0101, 0, 1, 4'b0100, 0, 0);
    repeat (3) cyc(0, 4'b0000, 0, 1, 4'b0100, 0, 0);
    repeat (2) cyc(0, 4'b0000, 0, 2, 4'b0100, 0, 0);
    cyc(0, 4'b0000, 0, 3, 4'b0000, 0, 1);
    cyc(0, 4'b0000, 0, 0, 4'b0000, 0, 0);

    // Zero timers, channel 3 held: one cycle per phase, ptr wraps to 0
    set_timers(8'd0, 8'd0, 8'd0, 8'd0);
    cyc(0, 4'b1000, 0, 1, 4'b1000, 0, 0);
    cyc(0, 4'b1000, 0, 2, 4'b1000, 0, 0);
    cyc(0, 4'b1000, 0, 3, 4'b0000, 0, 1);
    cyc(0, 4'b1000, 0, 0, 4'b0000, 0, 0);
    cyc(0, 4'b1000, 0, 1, 4'b1000, 0, 0);
    cyc(0, 4'b0000, 0, 2, 4'b1000, 0, 0);
    cyc(0, 4'b0000, 0, 3, 4'b0000, 0, 1);
    cyc(0, 4'b0000, 0, 0, 4'b0000, 0, 0);

    // john pulse mid-GREEN: pending until CLEAR ends, then 3 PED cycles
    set_timers(8'd3, 8'd1, 8'd0, 8'd2);
    cyc(0, 4'b0010, 0, 1, 4'b0010, 0, 0);
    cyc(0, 4'b0000, 1, 1, 4'b0010, 1, 0);
    repeat (2) cyc(0, 4'b0000, 0, 1, 4'b0010, 1, 0);
    repeat (2) cyc(0, 4'b0000, 0, 2, 4'b0010, 1, 0);
    cyc(0, 4'b0000, 0, 3, 4'b0000, 1, 1);
    repeat (3) cyc(0, 4'b0000, 0, 4, 4'b0000, 0, 0);
    cyc(0, 4'b0000, 0, 0, 4'b0000, 0, 0);

    // john and req together in IDLE: PED wins, request served afterwards
    cyc(0, 4'b0010, 1, 4, 4'b0000, 0, 0);
    repeat (2) cyc(0, 4'b0010, 0, 4, 4'b0000, 0, 0);
    cyc(0, 4'b0010, 0, 0, 4'b0000, 0, 0);
    cyc(0, 4'b0010, 0, 1, 4'b0010, 0, 0);
    repeat (3) cyc(0, 4'b0000, 0, 1, 4'b0010, 0, 0);
    cyc(0, 4'b0000, 0, 2, 4'b0010, 0, 0);

    // Reset during YELLOW: no done pulse, ptr back to 0 (req=1010 picks channel 1)
    cyc(1, 4'b0000, 0, 0, 4'b0000, 0, 0);
    cyc(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    cyc(0, 4'b1010, 0, 1, 4'b0010, 0, 0);
    cyc(0, 4'b0000, 0, 1, 4'b0010, 0, 0);

    repeat (2) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
